// File: rtl/gshare_predictor_pkg.sv
// Shared definitions for the gshare predictor: counter encodings, saturating
// update, B-type immediate extraction and the BRANCH opcode.
package gshare_predictor_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_ST) res = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) res = ctr - 2'd1;
        end
        return res;
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/gshare_predictor_pht.sv
// Pattern history table: 2^IDX_W two-bit saturating counters with one
// combinational read port and one synchronous saturating-update port.
module gshare_pht
    import gshare_predictor_pkg::*;
#(
    parameter int         IDX_W   = 6,
    parameter logic [1:0] CTR_RST = 2'b01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] ridx,
    output logic [1:0]       rctr,
    input  logic             we,
    input  logic [IDX_W-1:0] widx,
    input  logic             wtaken,
    output logic [1:0]       wctr
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0] ctr_q [DEPTH];

    assign rctr = ctr_q[ridx];
    // Post-update value of the entry being written; the top may forward it.
    assign wctr = ctr_update(ctr_q[widx], wtaken);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_RST;
        end else if (we) begin
            ctr_q[widx] <= wctr;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch predictor: PC xor global history indexes a PHT of 2-bit counters.
// Define GSHARE_SPEC_HIST_EN for speculative history with mispredict repair and PHT forwarding.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int         IDX_W   = 6,
    parameter int         HIST_W  = 6,
    parameter logic [1:0] CTR_RST = 2'b01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              pred_en,
    input  logic [31:0]       pred_pc,
    input  logic [31:0]       pred_inst,
    output logic              pred_out_en,
    output logic              pred,
    output logic [31:0]       pred_addr,
    output logic [HIST_W-1:0] pred_hist,
    input  logic              br_en,
    input  logic              br_taken,
    input  logic              br_mistaken,
    input  logic [31:0]       br_pc,
    input  logic [HIST_W-1:0] br_hist
);

    logic [HIST_W-1:0] ghr_q, ghr_d;
    logic              pred_out_en_q, pred_out_en_d;
    logic              pred_q, pred_d;
    logic [31:0]       pred_addr_q, pred_addr_d;
    logic [HIST_W-1:0] pred_hist_q, pred_hist_d;

    logic [IDX_W-1:0]  pidx, uidx;
    logic [1:0]        rd_ctr, wr_ctr;
    logic              pred_bit;
    logic [HIST_W:0]   ghr_ext;
    logic [HIST_W:0]   repair_ext;

    assign pidx = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
    assign uidx = br_pc[IDX_W+1:2]   ^ IDX_W'(br_hist);

    gshare_pht #(
        .IDX_W   (IDX_W),
        .CTR_RST (CTR_RST)
    ) u_pht (
        .clk    (clk),
        .rst    (rst),
        .ridx   (pidx),
        .rctr   (rd_ctr),
        .we     (rdy & br_en),
        .widx   (uidx),
        .wtaken (br_taken),
        .wctr   (wr_ctr)
    );

    always_comb begin
        pred_bit = rd_ctr[1];
`ifdef GSHARE_SPEC_HIST_EN
        if (br_en && (uidx == pidx)) pred_bit = wr_ctr[1];
`endif
    end

    // The extra low bit lets one slice express the shift for any HIST_W >= 1.
    always_comb begin
        ghr_d      = ghr_q;
        ghr_ext    = {ghr_q, br_taken};
        repair_ext = {br_hist, br_taken};
`ifdef GSHARE_SPEC_HIST_EN
        if (br_en && br_mistaken) begin
            ghr_d = repair_ext[HIST_W-1:0];
        end else if (pred_en) begin
            ghr_ext = {ghr_q, pred_bit};
            ghr_d   = ghr_ext[HIST_W-1:0];
        end
`else
        if (br_en) ghr_d = ghr_ext[HIST_W-1:0];
`endif
    end

    always_comb begin
        pred_out_en_d = pred_en;
        pred_d        = pred_bit;
        pred_hist_d   = ghr_q;
        pred_addr_d   = pred_pc + (pred_bit ? b_imm(pred_inst) : 32'd4);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q         <= '0;
            pred_out_en_q <= 1'b0;
            pred_q        <= 1'b0;
            pred_addr_q   <= '0;
            pred_hist_q   <= '0;
        end else if (rdy) begin
            ghr_q         <= ghr_d;
            pred_out_en_q <= pred_out_en_d;
            pred_q        <= pred_d;
            pred_addr_q   <= pred_addr_d;
            pred_hist_q   <= pred_hist_d;
        end
    end

    assign pred_out_en = pred_out_en_q;
    assign pred        = pred_q;
    assign pred_addr   = pred_addr_q;
    assign pred_hist   = pred_hist_q;

    logic unused_bits;
    assign unused_bits = ^{(pred_inst[6:0] == OPC_BRANCH), pred_inst, br_pc,
                           br_mistaken, rd_ctr[0], wr_ctr[0], repair_ext};

endmodule
